// File: rtl/health_monitor_seq_if.sv
// Sample/status bus between the sensor front-end sampler and the health monitor.
// The master side drives samples and the alarm ack. The slave side returns status and alarm.
interface health_monitor_seq_if #(
    parameter int P_W  = 6,
    parameter int FD_W = 8
);
    logic            sample_valid;
    logic [P_W-1:0]  pressure_data;
    logic [3:0]      blood_ph;
    logic [2:0]      blood_type;
    logic [FD_W-1:0] fd_sensor;
    logic [FD_W-1:0] fd_factory;
    logic [7:0]      blood_sensor;
    logic [4:0]      base_temp;
    logic [3:0]      temp_coef;
    logic [3:0]      temp_sensor;
    logic            alarm_ack;

    logic            status_valid;
    logic            pressure_abn;
    logic            blood_abn;
    logic            low_temp_abn;
    logic            high_temp_abn;
    logic            fall_detected;
    logic [3:0]      glycemic_index;
    logic            alarm;
    logic [4:0]      alarm_cause;

    modport master (
        output sample_valid, pressure_data, blood_ph, blood_type, fd_sensor, fd_factory,
               blood_sensor, base_temp, temp_coef, temp_sensor, alarm_ack,
        input  status_valid, pressure_abn, blood_abn, low_temp_abn, high_temp_abn,
               fall_detected, glycemic_index, alarm, alarm_cause
    );

    modport slave (
        input  sample_valid, pressure_data, blood_ph, blood_type, fd_sensor, fd_factory,
               blood_sensor, base_temp, temp_coef, temp_sensor, alarm_ack,
        output status_valid, pressure_abn, blood_abn, low_temp_abn, high_temp_abn,
               fall_detected, glycemic_index, alarm, alarm_cause
    );
endinterface

// File: rtl/health_monitor_seq.sv
// Two-stage vital-sign monitor. Stage 1 registers the raw abnormality flags.
// Stage 2 applies persistence counters and drives the latched alarm.
module health_monitor_seq #(
    parameter int P_W        = 6,
    parameter int P_LOW      = 10,
    parameter int P_HIGH     = 50,
    parameter int FD_W       = 8,
    parameter int FALL_DELTA = 40,
    parameter int T_LOW      = 34,
    parameter int T_HIGH     = 39,
    parameter int PERSIST    = 3
) (
    input logic               clk,
    input logic               rst_n,
    health_monitor_seq_if.slave bus
);
    localparam logic [3:0] PersistCnt = 4'(PERSIST);

    typedef struct packed {
        logic fall;
        logic highT;
        logic lowT;
        logic blood;
        logic press;
    } causeT;

    logic [8:0]  tempNow;
    logic [FD_W:0] fdA, fdB, fdDiff;
    logic        rawPress, rawBlood, rawLowT, rawHighT, rawFall;

    logic        s1Valid, s1Press, s1Blood, s1LowT, s1HighT, s1Fall;
    logic [3:0]  s1Glyc;

    logic [3:0]  pressCnt, bloodCnt, lowCnt, highCnt;
    logic [3:0]  pressNext, bloodNext, lowNext, highNext;
    logic        pressFlag, bloodFlag, lowFlag, highFlag;
    causeT       setBits;

    // Saturating persistence counter; any normal sample restarts the run.
    function automatic logic [3:0] nextCount(input logic [3:0] cnt, input logic abn);
        if (!abn)                return 4'd0;
        else if (cnt >= PersistCnt) return PersistCnt;
        else                     return cnt + 4'd1;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        tempNow  = 9'(bus.base_temp) + 9'(bus.temp_coef) * 9'(bus.temp_sensor);
        fdA      = {1'b0, bus.fd_sensor};
        fdB      = {1'b0, bus.fd_factory};
        fdDiff   = (fdA > fdB) ? (fdA - fdB) : (fdB - fdA);
        rawPress = (bus.pressure_data < P_W'(P_LOW)) || (bus.pressure_data > P_W'(P_HIGH));
        rawBlood = (bus.blood_ph < 4'd7) || (bus.blood_ph > 4'd9) || (bus.blood_type == 3'b111);
        rawLowT  = tempNow < 9'(T_LOW);
        rawHighT = tempNow > 9'(T_HIGH);
        rawFall  = fdDiff > (FD_W + 1)'(FALL_DELTA);
    end

    always_comb begin
        pressNext = nextCount(pressCnt, s1Press);
        bloodNext = nextCount(bloodCnt, s1Blood);
        lowNext   = nextCount(lowCnt, s1LowT);
        highNext  = nextCount(highCnt, s1HighT);
        pressFlag = pressNext == PersistCnt;
        bloodFlag = bloodNext == PersistCnt;
        lowFlag   = lowNext == PersistCnt;
        highFlag  = highNext == PersistCnt;
        setBits   = '0;
        if (s1Valid) begin
            setBits.fall  = s1Fall;
            setBits.highT = highFlag & ~bus.high_temp_abn;
            setBits.lowT  = lowFlag & ~bus.low_temp_abn;
            setBits.blood = bloodFlag & ~bus.blood_abn;
            setBits.press = pressFlag & ~bus.pressure_abn;
        end
    end

    // NOTE: all state here updates with <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid            <= 1'b0;
            s1Press            <= 1'b0;
            s1Blood            <= 1'b0;
            s1LowT             <= 1'b0;
            s1HighT            <= 1'b0;
            s1Fall             <= 1'b0;
            s1Glyc             <= 4'd0;
            pressCnt           <= 4'd0;
            bloodCnt           <= 4'd0;
            lowCnt             <= 4'd0;
            highCnt            <= 4'd0;
            bus.status_valid   <= 1'b0;
            bus.pressure_abn   <= 1'b0;
            bus.blood_abn      <= 1'b0;
            bus.low_temp_abn   <= 1'b0;
            bus.high_temp_abn  <= 1'b0;
            bus.fall_detected  <= 1'b0;
            bus.glycemic_index <= 4'd0;
            bus.alarm          <= 1'b0;
            bus.alarm_cause    <= 5'd0;
        end else begin
            s1Valid <= bus.sample_valid;
            if (bus.sample_valid) begin
                s1Press <= rawPress;
                s1Blood <= rawBlood;
                s1LowT  <= rawLowT;
                s1HighT <= rawHighT;
                s1Fall  <= rawFall;
                s1Glyc  <= bus.blood_sensor[7:4];
            end

            bus.status_valid <= s1Valid;
            if (s1Valid) begin
                pressCnt           <= pressNext;
                bloodCnt           <= bloodNext;
                lowCnt             <= lowNext;
                highCnt            <= highNext;
                bus.pressure_abn   <= pressFlag;
                bus.blood_abn      <= bloodFlag;
                bus.low_temp_abn   <= lowFlag;
                bus.high_temp_abn  <= highFlag;
                bus.fall_detected  <= s1Fall;
                bus.glycemic_index <= s1Glyc;
            end

            // A set event beats a simultaneous ack, leaving only the new cause bits.
            if (bus.alarm_ack) begin
                bus.alarm       <= |setBits;
                bus.alarm_cause <= setBits;
            end else if (|setBits) begin
                bus.alarm       <= 1'b1;
                bus.alarm_cause <= bus.alarm_cause | setBits;
            end
        end
    end
endmodule
